syncedge_bank: RTL and testbench



---
 rtl/syncedge_bank.sv | 132 +++++++++++++
 tb/tb_syncedge_bank.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/syncedge_bank.sv
// syncedge_bank: multi-channel synchronised edge detector. Each channel has an
// optional input synchroniser, selectable edge mode, a holdoff (dead-time)
// counter and a sticky event flag. Detection is suppressed for a short
// warm-up window after reset so that lines held through reset make no event.

// One channel: sync chain, previous-level register, edge qualify, holdoff, sticky.
module syncedge_lane #(
  parameter int    SYNC_STAGES  = 2,
  parameter string EDGE         = "RISING",
  parameter int    HOLDOFF_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  input  logic                    warm,
  input  logic [HOLDOFF_BITS-1:0] holdoff,
  input  logic                    clr,
  output logic                    pulse,
  output logic                    sticky
);

  localparam logic [HOLDOFF_BITS-1:0] CNT_ONE = 1;

  logic                    lvl;
  logic                    prv;
  logic                    edge_c;
  logic                    accept;
  logic [HOLDOFF_BITS-1:0] cnt;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign lvl = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync;
      // Synchroniser chain; lvl is the last stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          sync <= '0;
        end else begin
          sync[0] <= din;
          for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
        end
      end
      assign lvl = sync[SYNC_STAGES-1];
    end
  endgenerate

  // Any EDGE value other than FALLING/BOTH behaves as RISING.
  generate
    if (EDGE == "FALLING") begin : g_fall
      assign edge_c = ~lvl & prv;
    end else if (EDGE == "BOTH") begin : g_both
      assign edge_c = lvl ^ prv;
    end else begin : g_rise
      assign edge_c = lvl & ~prv;
    end
  endgenerate

  // Edges arriving while the counter runs are dropped, not queued.
  assign accept = edge_c & warm & (cnt == '0);

  // Previous level, holdoff count, strobe and sticky flag (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      prv    <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      prv   <= lvl;
      pulse <= accept;
      if (accept)          cnt <= holdoff;
      else if (cnt != '0)  cnt <= cnt - CNT_ONE;
      if (accept)          sticky <= 1'b1;
      else if (clr)        sticky <= 1'b0;
    end
  end

endmodule

// Top: shared warm-up shift register plus an array of channel lanes.
module syncedge_bank #(
  parameter int    NCH          = 8,
  parameter int    SYNC_STAGES  = 2,
  parameter string EDGE         = "RISING",
  parameter int    HOLDOFF_BITS = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NCH-1:0]          I,
  input  logic [HOLDOFF_BITS-1:0] HOLDOFF,
  input  logic [NCH-1:0]          CLR,
  output logic [NCH-1:0]          O,
  output logic [NCH-1:0]          STICKY,
  output logic                    ANY
);

  // One bit per sync stage plus one for the previous-level register, so the
  // first edge seen after reset compares two genuinely sampled levels.
  logic [SYNC_STAGES:0] vld_pipe;
  logic                 warm;

  // Warm-up shift register: fills with ones after reset release.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= 1'b1;
      for (int k = 1; k <= SYNC_STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  assign warm = vld_pipe[SYNC_STAGES];

  syncedge_lane #(
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE        (EDGE),
    .HOLDOFF_BITS(HOLDOFF_BITS)
  ) u_lane [NCH-1:0] (
    .clk    (CLK),
    .rst    (RST),
    .din    (I),
    .warm   (warm),
    .holdoff(HOLDOFF),
    .clr    (CLR),
    .pulse  (O),
    .sticky (STICKY)
  );

  assign ANY = |O;

endmodule

// File: tb/tb_syncedge_bank.sv
// Directed bench for syncedge_bank: a cycle table on a default-parameter
// instance, plus hand sequences on a BOTH-mode instance and a legacy-style
// unsynchronised FALLING instance.
module tb_syncedge_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (8 ch, 2 sync stages, RISING)
  logic       rst_a;
  logic [7:0] i_a, clr_a, o_a, st_a;
  logic [3:0] ho_a;
  logic       any_a;
  syncedge_bank u_a (
    .CLK(clk), .RST(rst_a), .I(i_a), .HOLDOFF(ho_a), .CLR(clr_a),
    .O(o_a), .STICKY(st_a), .ANY(any_a)
  );

  // Instance B: BOTH edges
  logic       rst_b;
  logic [7:0] i_b, clr_b, o_b, st_b;
  logic [3:0] ho_b;
  logic       any_b;
  syncedge_bank #(.EDGE("BOTH")) u_b (
    .CLK(clk), .RST(rst_b), .I(i_b), .HOLDOFF(ho_b), .CLR(clr_b),
    .O(o_b), .STICKY(st_b), .ANY(any_b)
  );

  // Instance C: 1 ch, no sync, FALLING
  logic       rst_c, i_c, clr_c, o_c, st_c, any_c;
  logic [3:0] ho_c;
  syncedge_bank #(.NCH(1), .SYNC_STAGES(0), .EDGE("FALLING")) u_c (
    .CLK(clk), .RST(rst_c), .I(i_c), .HOLDOFF(ho_c), .CLR(clr_c),
    .O(o_c), .STICKY(st_c), .ANY(any_c)
  );

  typedef struct {
    logic       rst;
    logic [7:0] i;
    logic [3:0] ho;
    logic [7:0] clr;
    logic [7:0] o;
    logic [7:0] st;
  } vec_t;

  vec_t tbl[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic add(input logic rst, input logic [7:0] i, input logic [3:0] ho,
                     input logic [7:0] clr, input logic [7:0] o, input logic [7:0] st);
    vec_t v;
    v.rst = rst; v.i = i; v.ho = ho; v.clr = clr; v.o = o; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one channel of B row by row; pat bit k is I[ch] for row k, exp bit k
  // the O[ch] value right after that row's edge.
  task automatic run_b(input string name, input int ch, input int n,
                       input logic [31:0] pat, input logic [3:0] ho1,
                       input logic [3:0] ho2, input int sw, input logic [31:0] exp);
    logic [31:0] got_o;
    logic [31:0] got_any;
    got_o   = '0;
    got_any = '0;
    for (int k = 0; k < n; k++) begin
      i_b[ch] = pat[k];
      ho_b    = (k < sw) ? ho1 : ho2;
      @(posedge clk); #1;
      got_o[k]   = o_b[ch];
      got_any[k] = any_b;
    end
    check({name, " O"}, got_o, exp);
    check({name, " ANY"}, got_any, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got_c;
    logic [7:0]  pat_c;

    rst_a = 1'b1; i_a = 8'h08; ho_a = '0; clr_a = '0;
    rst_b = 1'b1; i_b = '0;    ho_b = '0; clr_b = '0;
    rst_c = 1'b1; i_c = 1'b1;  ho_c = '0; clr_c = 1'b0;

    // rst, I, HOLDOFF, CLR, exp O, exp STICKY
    add(1, 8'h08, 0, 8'h00, 8'h00, 8'h00);        // 0  ch3 high through reset
    add(1, 8'h08, 0, 8'h00, 8'h00, 8'h00);        // 1
    for (int k = 2; k < 10; k++)
      add(0, 8'h08, 0, 8'h00, 8'h00, 8'h00);      // 2-9 warm-up, no ch3 event
    add(0, 8'h09, 0, 8'h00, 8'h00, 8'h00);        // 10 ch0 rises
    add(0, 8'h09, 0, 8'h00, 8'h00, 8'h00);        // 11
    add(0, 8'h09, 0, 8'h00, 8'h01, 8'h01);        // 12 ch0 strobe
    add(0, 8'h09, 0, 8'h00, 8'h00, 8'h01);        // 13
    add(0, 8'h01, 0, 8'h00, 8'h00, 8'h01);        // 14 ch3 low
    add(0, 8'h09, 0, 8'h00, 8'h00, 8'h01);        // 15 ch3 high again
    add(0, 8'h09, 0, 8'h00, 8'h00, 8'h01);        // 16 falling ignored
    add(0, 8'h09, 0, 8'h00, 8'h08, 8'h09);        // 17 ch3 strobe
    add(0, 8'h0D, 0, 8'h00, 8'h00, 8'h09);        // 18 ch2 rises
    add(0, 8'h0D, 0, 8'h00, 8'h00, 8'h09);        // 19
    add(0, 8'h0D, 0, 8'h00, 8'h04, 8'h0D);        // 20 ch2 strobe
    add(0, 8'h09, 0, 8'h00, 8'h00, 8'h0D);        // 21 ch2 low
    add(0, 8'h0D, 0, 8'h00, 8'h00, 8'h0D);        // 22 ch2 high
    add(0, 8'h0D, 0, 8'h00, 8'h00, 8'h0D);        // 23
    add(0, 8'h0D, 0, 8'h04, 8'h04, 8'h0D);        // 24 accept + CLR: set wins
    add(0, 8'h0D, 0, 8'h04, 8'h00, 8'h09);        // 25 CLR alone clears
    add(0, 8'h0D, 0, 8'h00, 8'h00, 8'h09);        // 26
    add(0, 8'h2D, 7, 8'h00, 8'h00, 8'h09);        // 27 ch5 rises, holdoff 7
    add(0, 8'h2D, 7, 8'h00, 8'h00, 8'h09);        // 28
    add(0, 8'h2D, 7, 8'h00, 8'h20, 8'h29);        // 29 ch5 strobe, count loaded
    add(0, 8'h2D, 7, 8'h00, 8'h00, 8'h29);        // 30
    add(1, 8'h00, 7, 8'h00, 8'h00, 8'h00);        // 31 reset mid-holdoff
    add(0, 8'h40, 7, 8'h00, 8'h00, 8'h00);        // 32 ch6 rises too early
    add(0, 8'h60, 7, 8'h00, 8'h00, 8'h00);        // 33 ch5 rises
    add(0, 8'h60, 7, 8'h00, 8'h00, 8'h00);        // 34 ch6 edge lands in warm-up
    add(0, 8'h60, 7, 8'h00, 8'h20, 8'h20);        // 35 ch5 accepted, no residue
    add(0, 8'h60, 7, 8'h00, 8'h00, 8'h20);        // 36

    foreach (tbl[k]) begin
      rst_a = tbl[k].rst; i_a = tbl[k].i; ho_a = tbl[k].ho; clr_a = tbl[k].clr;
      rst_b = (k < 2);
      @(posedge clk); #1;
      check($sformatf("row%0d O", k), o_a, tbl[k].o);
      check($sformatf("row%0d STICKY", k), st_a, tbl[k].st);
      check($sformatf("row%0d ANY", k), any_a, |tbl[k].o);
    end

    // BOTH, holdoff 3, 12 toggles -> strobes every 4 cycles
    run_b("both_hold3", 1, 20, 32'h0000_0555, 4'd3, 4'd3, 0, 32'h0000_0444);
    // BOTH, no holdoff, 1-cycle glitch -> two back-to-back strobes
    run_b("both_glitch", 4, 8, 32'h0000_0001, 4'd0, 4'd0, 0, 32'h0000_000C);
    // HOLDOFF drops from 5 to 1 mid-count; running count is unaffected
    run_b("hold_change", 7, 14, 32'h0000_3FC7, 4'd5, 4'd1, 3, 32'h0000_0104);
    check("b STICKY", st_b, 8'h92);

    // Instance C: reset state, then legacy falling-edge behaviour
    check("c reset O", o_c, 1'b0);
    check("c reset STICKY", st_c, 1'b0);
    rst_c = 1'b0;
    pat_c = 8'h69;
    got_c = '0;
    for (int k = 0; k < 7; k++) begin
      i_c = pat_c[k];
      @(posedge clk); #1;
      got_c[k] = o_c;
      check($sformatf("c row%0d ANY", k), any_c, o_c);
    end
    check("c fall O", got_c, 32'h12);
    check("c STICKY set", st_c, 1'b1);
    clr_c = 1'b1;
    @(posedge clk); #1;
    clr_c = 1'b0;
    check("c STICKY clr", st_c, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
